// File: rtl/uart_frame_receiver.sv
// UART 8N1 receiver that packs BYTES_PER_FRAME bytes into one frame, first byte in the MSBs.
// Optional mid-frame idle timeout: define RX_FRAME_TIMEOUT_EN.
module uart_frame_receiver #(
    parameter int unsigned CLKS_PER_BIT    = 10416,
    parameter int unsigned BYTES_PER_FRAME = 3,
    parameter int unsigned TIMEOUT_CLKS    = 100000000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         RxD,
    output logic [7:0]                   byte_data,
    output logic                         byte_valid,
    output logic [8*BYTES_PER_FRAME-1:0] frame_data,
    output logic                         frame_valid,
    output logic                         framing_error,
    output logic                         busy
);

    localparam int unsigned FRAME_W = 8 * BYTES_PER_FRAME;
    localparam int unsigned CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W   = (BYTES_PER_FRAME > 1) ? $clog2(BYTES_PER_FRAME) : 1;

    localparam logic [CNT_W-1:0] HALF_TC  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_TC   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_FRAME - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StWaitHigh
    } state_e;

    state_e             r_state;
    logic               r_rx_meta;
    logic               r_rx_sync;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic [IDX_W-1:0]   r_byte_idx;
    logic [FRAME_W-1:0] r_shadow;
    logic [7:0]         r_byte_data;
    logic               r_byte_valid;
    logic [FRAME_W-1:0] r_frame_data;
    logic               r_frame_valid;
    logic               r_framing_error;

    logic               w_rx_s;
    logic [FRAME_W-1:0] w_assembled;

`ifdef RX_FRAME_TIMEOUT_EN
    localparam int unsigned          IDLE_W  = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [IDLE_W-1:0]    IDLE_TC = IDLE_W'(TIMEOUT_CLKS - 1);
    logic [IDLE_W-1:0]               r_idle_cnt;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= RxD;
            r_rx_sync <= r_rx_meta;
        end
    end

    assign w_rx_s = r_rx_sync;

    // Shadow copy with the current byte dropped into its slot; index 0 lands in the MSBs.
    always_comb begin
        w_assembled = r_shadow;
        for (int i = 0; i < BYTES_PER_FRAME; i++) begin
            if (r_byte_idx == IDX_W'(BYTES_PER_FRAME - 1 - i)) begin
                w_assembled[i*8 +: 8] = r_shift;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= StIdle;
            r_bit_cnt       <= '0;
            r_bit_idx       <= '0;
            r_shift         <= '0;
            r_byte_idx      <= '0;
            r_shadow        <= '0;
            r_byte_data     <= '0;
            r_byte_valid    <= 1'b0;
            r_frame_data    <= '0;
            r_frame_valid   <= 1'b0;
            r_framing_error <= 1'b0;
        end else begin
            r_byte_valid    <= 1'b0;
            r_frame_valid   <= 1'b0;
            r_framing_error <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (!w_rx_s) begin
                        r_state   <= StStart;
                        r_bit_cnt <= '0;
                    end
                end
                StStart: begin
                    if (r_bit_cnt == HALF_TC) begin
                        r_bit_cnt <= '0;
                        r_bit_idx <= '0;
                        r_state   <= w_rx_s ? StIdle : StData;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                StData: begin
                    if (r_bit_cnt == BIT_TC) begin
                        r_bit_cnt <= '0;
                        r_shift   <= {w_rx_s, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= StStop;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                StStop: begin
                    if (r_bit_cnt == BIT_TC) begin
                        r_bit_cnt <= '0;
                        if (w_rx_s) begin
                            r_byte_data  <= r_shift;
                            r_byte_valid <= 1'b1;
                            r_shadow     <= w_assembled;
                            r_state      <= StIdle;
                            if (r_byte_idx == LAST_IDX) begin
                                r_frame_data  <= w_assembled;
                                r_frame_valid <= 1'b1;
                                r_byte_idx    <= '0;
                            end else begin
                                r_byte_idx <= r_byte_idx + 1'b1;
                            end
                        end else begin
                            r_framing_error <= 1'b1;
                            r_byte_idx      <= '0;
                            r_state         <= StWaitHigh;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                StWaitHigh: begin
                    if (w_rx_s) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
`ifdef RX_FRAME_TIMEOUT_EN
            // A start detect takes priority over the timeout in the same cycle.
            if (r_state == StIdle && r_byte_idx != '0 && w_rx_s) begin
                if (r_idle_cnt == IDLE_TC) begin
                    r_byte_idx      <= '0;
                    r_framing_error <= 1'b1;
                end
            end
`endif
        end
    end

`ifdef RX_FRAME_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idle_cnt <= '0;
        end else if (r_state == StIdle && r_byte_idx != '0 && w_rx_s
                     && r_idle_cnt != IDLE_TC) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end else begin
            r_idle_cnt <= '0;
        end
    end
`endif

    assign byte_data     = r_byte_data;
    assign byte_valid    = r_byte_valid;
    assign frame_data    = r_frame_data;
    assign frame_valid   = r_frame_valid;
    assign framing_error = r_framing_error;
    assign busy          = (r_state != StIdle) || (r_byte_idx != '0);

endmodule

// File: tb/tb_uart_frame_receiver.sv
// Directed bench for uart_frame_receiver with a shortened bit period and timeout.
module tb_uart_frame_receiver;

    localparam int unsigned CPB = 16;
    localparam int unsigned BPF = 3;
    localparam int unsigned TMO = 2000;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          RxD = 1'b1;
    logic [7:0]    byte_data;
    logic          byte_valid;
    logic [23:0]   frame_data;
    logic          frame_valid;
    logic          framing_error;
    logic          busy;

    int            total = 0;
    int            bad = 0;
    int            n_bytes = 0;
    int            n_frames = 0;
    int            n_ferr = 0;
    int            n_nocoinc = 0;
    logic [7:0]    blog[$];

    always #5 clk = ~clk;

    uart_frame_receiver #(
        .CLKS_PER_BIT    (CPB),
        .BYTES_PER_FRAME (BPF),
        .TIMEOUT_CLKS    (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .RxD           (RxD),
        .byte_data     (byte_data),
        .byte_valid    (byte_valid),
        .frame_data    (frame_data),
        .frame_valid   (frame_valid),
        .framing_error (framing_error),
        .busy          (busy)
    );

    always @(negedge clk) begin
        if (reset) begin
            if (byte_valid) begin
                n_bytes++;
                blog.push_back(byte_data);
            end
            if (frame_valid) begin
                n_frames++;
                if (!byte_valid) n_nocoinc++;
            end
            if (framing_error) n_ferr++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic v);
        RxD = v;
        idle(CPB);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input int gap_bits);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        RxD = 1'b1;
        idle(gap_bits * CPB);
    endtask

    task automatic clear_log();
        n_bytes  = 0;
        n_frames = 0;
        n_ferr   = 0;
        blog.delete();
    endtask

    task automatic check_log(input string tag, input logic [7:0] e[$]);
        check({tag, "_nbytes"}, n_bytes, e.size());
        for (int i = 0; i < e.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i),
                  (i < blog.size()) ? {24'h0, blog[i]} : 32'hdead_beef, {24'h0, e[i]});
        end
    endtask

    initial begin
        idle(3);
        #1;
        check("rst_byte_data", byte_data, 0);
        check("rst_frame_data", frame_data, 0);
        check("rst_busy", busy, 0);
        check("rst_pulses", {byte_valid, frame_valid, framing_error}, 0);
        @(negedge clk);
        reset = 1'b1;
        idle(4);

        // Basic frame
        clear_log();
        send_byte(8'h41, 1'b1, 3);
        check("t1_busy_partial", busy, 1);
        send_byte(8'h42, 1'b1, 3);
        send_byte(8'h43, 1'b1, 3);
        check_log("t1", '{8'h41, 8'h42, 8'h43});
        check("t1_nframes", n_frames, 1);
        check("t1_frame", frame_data, 24'h414243);
        check("t1_ferr", n_ferr, 0);
        check("t1_busy_done", busy, 0);

        // Short low glitch rejected in START
        clear_log();
        RxD = 1'b0;
        idle(4);
        check("gl_busy_start", busy, 1);
        RxD = 1'b1;
        idle(2 * CPB);
        check("gl_busy_end", busy, 0);
        check("gl_nbytes", n_bytes, 0);
        check("gl_ferr", n_ferr, 0);

        // Bad stop bit drops the partial frame
        clear_log();
        send_byte(8'h55, 1'b1, 3);
        send_byte(8'hAA, 1'b0, 3);
        check("fe_ferr", n_ferr, 1);
        check("fe_frame_hold", frame_data, 24'h414243);
        check("fe_busy", busy, 0);
        send_byte(8'h01, 1'b1, 3);
        send_byte(8'h02, 1'b1, 3);
        send_byte(8'h03, 1'b1, 3);
        check_log("fe", '{8'h55, 8'h01, 8'h02, 8'h03});
        check("fe_nframes", n_frames, 1);
        check("fe_frame", frame_data, 24'h010203);

        // Async reset in the middle of the second byte
        clear_log();
        send_byte(8'h41, 1'b1, 3);
        send_bit(1'b0);
        send_bit(1'b1);
        RxD = 1'b0;
        idle(CPB / 2);
        reset = 1'b0;
        #1;
        check("rs_byte_data", byte_data, 0);
        check("rs_frame_data", frame_data, 0);
        check("rs_busy", busy, 0);
        check("rs_pulses", {byte_valid, frame_valid, framing_error}, 0);
        idle(2);
        RxD = 1'b1;
        reset = 1'b1;
        idle(5);
        clear_log();
        send_byte(8'h10, 1'b1, 3);
        send_byte(8'h20, 1'b1, 3);
        send_byte(8'h30, 1'b1, 3);
        check_log("rs", '{8'h10, 8'h20, 8'h30});
        check("rs_frame", frame_data, 24'h102030);
        check("rs_ferr", n_ferr, 0);

        // Back-to-back bytes, no idle between stop and next start
        clear_log();
        send_byte(8'hFF, 1'b1, 0);
        send_byte(8'h00, 1'b1, 0);
        send_byte(8'h7E, 1'b1, 3);
        check_log("bb", '{8'hFF, 8'h00, 8'h7E});
        check("bb_nframes", n_frames, 1);
        check("bb_frame", frame_data, 24'hFF007E);
        check("bb_ferr", n_ferr, 0);

        // Long idle mid-frame
        clear_log();
        send_byte(8'h11, 1'b1, 0);
        idle(TMO + 1000);
`ifdef RX_FRAME_TIMEOUT_EN
        check("to_busy", busy, 0);
`else
        check("to_busy", busy, 1);
`endif
        send_byte(8'h22, 1'b1, 3);
        send_byte(8'h33, 1'b1, 3);
        send_byte(8'h44, 1'b1, 3);
        check("to_nframes", n_frames, 1);
`ifdef RX_FRAME_TIMEOUT_EN
        check("to_ferr", n_ferr, 1);
        check("to_frame", frame_data, 24'h223344);
`else
        check("to_ferr", n_ferr, 0);
        check("to_frame", frame_data, 24'h112233);
`endif

        check("frame_with_byte", n_nocoinc, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_frame_receiver.md
Name: uart_frame_receiver

Overview:
- Serial receive stage that consumes the UART stream produced by the 24-bit frame transmitter.
- Line format: 9600 baud, 8N1, LSB first.
- Oversamples RxD, recovers bytes, and packs BYTES_PER_FRAME consecutive bytes into one parallel frame for the Morse decode/display logic downstream.
- Flags framing errors and discards partial frames.

Parameters:
- CLKS_PER_BIT, 10416, clock cycles per bit period (100 MHz / 9600).
- BYTES_PER_FRAME, 3, bytes packed per frame; FRAME_W = 8*BYTES_PER_FRAME.
- TIMEOUT_CLKS, 100000000, idle clocks mid-frame before the partial frame is dropped (used only with RX_FRAME_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-low reset.
- RxD  in  1  serial input, idle high, asynchronous to clk.
- byte_data  out  8  last accepted byte.
- byte_valid  out  1  one-cycle pulse when byte_data updates.
- frame_data  out  FRAME_W  last complete frame; first received byte in [FRAME_W-1:FRAME_W-8].
- frame_valid  out  1  one-cycle pulse when frame_data updates.
- framing_error  out  1  one-cycle pulse on bad stop bit.
- busy  out  1  high in any state other than IDLE, or while a partial frame is held.

Behaviour:
- Reset (reset=0, async):
  - State IDLE; all counters cleared; byte index 0.
  - Synchroniser flops = 1.
  - byte_data=0, frame_data=0, all pulse outputs 0, busy=0.
- RxD passes through a 2-flop synchroniser (rx_s). All decisions use rx_s; 2-cycle input latency.
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE:
  - rx_s==0 -> START; clear the bit-clock counter.
- START:
  - Count to CLKS_PER_BIT/2-1 (5207).
  - At terminal count: rx_s==0 -> DATA with counter cleared; rx_s==1 -> IDLE (glitch rejected, no output).
- DATA:
  - Counter runs 0..CLKS_PER_BIT-1. At terminal count, sample rx_s into bit[k], k=0..7 (LSB first).
  - After bit 7 -> STOP.
- STOP:
  - At terminal count, sample rx_s.
  - Sample 1: next cycle byte_data<=byte and byte_valid=1. Byte stored at slot (BYTES_PER_FRAME-1-index); index++.
    - If index was BYTES_PER_FRAME-1: the same cycle drives frame_valid=1, frame_data<=assembled word (including this byte), index<=0.
    - -> IDLE.
  - Sample 0: framing_error=1 for one cycle; byte discarded; index<=0 (partial frame dropped) -> WAIT_HIGH.
- WAIT_HIGH:
  - Stay until rx_s==1, then -> IDLE. A held break never produces bytes.
- Back-to-back bytes with zero idle: the next start edge is detected from IDLE. Stop-sample-to-IDLE slack is half a bit; no bytes are lost.
- Inter-byte gaps inside a frame are unbounded: the upstream transmitter waits for a transmit request between bytes.
- frame_data holds its value until the next complete frame. Assembly occurs in a separate shadow register, so partial frames never appear on frame_data.
- Counter widths: bit counter is ceil(log2(CLKS_PER_BIT)) bits; byte index is ceil(log2(BYTES_PER_FRAME)) bits, minimum 1.

Optional Feature:
- Macro RX_FRAME_TIMEOUT_EN.
- When defined:
  - An idle counter runs while in IDLE with index!=0 and clears on any start detect.
  - Reaching TIMEOUT_CLKS sets index<=0 and asserts framing_error for one cycle (partial frame dropped).
  - busy falls the cycle after timeout.
- When undefined:
  - No idle counter.
  - A partial frame is held indefinitely until completed, a framing error, or reset.

Test Plan:
- Send 0x41, 0x42, 0x43, each 8N1 at 10416 clks/bit, 3-bit-time gaps -> byte_valid x3 with byte_data 0x41/0x42/0x43; one frame_valid with frame_data=0x414243, coincident with the third byte_valid.
- Drive RxD low for 3000 cycles, then high -> no byte_valid, no framing_error; busy returns 0 from START.
- Send 0x55, then 0xAA with stop bit 0, then 0x01, 0x02, 0x03 -> framing_error pulse after 0xAA; single frame_valid with frame_data=0x010203 (0x55 discarded).
- Assert reset low mid-DATA of the second byte -> all outputs 0 immediately; after release, 0x10, 0x20, 0x30 yields frame_data=0x102030.
- Send 0xFF, 0x00, 0x7E with zero idle between stop and next start -> frame_data=0xFF007E, no error.
- With RX_FRAME_TIMEOUT_EN and TIMEOUT_CLKS=50000:
  - Send 0x11, idle 60000 cycles, then 0x22, 0x33, 0x44 -> framing_error once; frame_data=0x223344.
  - Without the macro, the same stimulus -> frame_data=0x112233.
